game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  - Master game FSM (INIT/PLAY/DEAD) with per-frame pixel-overlap collision detection.
//  - Consumes dino and obstacle pixel-coverage flags from the sprite delegates, plus the debounced jump button.
//  - Produces gameState for the background, obstacle and score delegates, and a restart pulse.
//  - Sits directly upstream of the game delegates in top_vga.
// PARAMETERS
//  HIT_THRESH   4   overlapping samples per frame needed to declare a hit (glitch filter)
//  GRACE_FRAMES 8   frames after entering PLAY during which hits are ignored
//  DEAD_HOLD    30  frames in DEAD before jump may restart
//  CNT_W        12  width of overlap counter (saturating)
// PORTS
//  clk          in   1  100MHz system clock; sole clock
//  rst          in   1  synchronous, active-high reset
//  frame_clk    in   1  Frame_Clk from VGA, treated as data: synchronised, rising edge = frame tick
//  jump         in   1  debounced jump level
//  dino_px      in   1  dino_inGrey|dino_inWhite for current scan pixel
//  obs_px       in   1  obstacle_inGrey|obstacle_inWhite for current scan pixel
//  gameState    out  2  00 INIT, 01 PLAY, 10 DEAD (11 never driven)
//  restart      out  1  1-cycle pulse on DEAD->INIT
//  hit          out  1  sticky: set on PLAY->DEAD, cleared on entry to INIT
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): gameState=00, restart=0, hit=0.
//    Overlap count, grace/hold counters and both synchroniser chains = 0.
//  - frame_clk and jump each pass a 2-FF synchroniser plus rising-edge detector.
//    frame_tick / jump_rise are 1-cycle pulses, 3 clk after the input edge.
//  - Overlap counter:
//    +1 per clk with dino_px&obs_px; saturates at 2^CNT_W-1.
//    On frame_tick: evaluated, then cleared; an overlap in the same cycle is dropped.
//  - INIT: jump_rise -> PLAY (next clk); grace counter loaded with GRACE_FRAMES.
//  - PLAY:
//    - Each frame_tick decrements grace (stops at 0).
//    - Hit when frame_tick & grace==0 & count>=HIT_THRESH -> DEAD, hit=1.
//    - A hit frame during grace is discarded, never deferred.
//    - jump ignored.
//  - DEAD:
//    - Hold counter loaded with DEAD_HOLD on entry; decremented per frame_tick, stops at 0.
//    - jump_rise with hold==0 -> INIT, restart=1 for exactly that one clk, hit cleared.
//    - jump_rise with hold!=0 ignored; a held jump does not fire later (edge, not level).
//  - Overlap in INIT/DEAD is counted but never evaluated.
//  - Simultaneous jump_rise and frame_tick in INIT: go PLAY; counter cleared; grace = GRACE_FRAMES (no decrement that cycle).
//  - rst mid-operation wins over every transition; restart is not pulsed by rst.
//  - Latency: input edge to gameState change = 4 clk (3 sync/edge + 1 state reg).
//  - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package/include trex_defs:
//    - ST_INIT=2'b00, ST_PLAY=2'b01, ST_DEAD=2'b10 (also used by GameDelegate consumers).
//  - Sub-module edge_sync (2-FF sync + rising-edge pulse), instantiated twice (frame_clk, jump).
//  - Top body: one state register, overlap counter, shared grace/hold down-counter (width covers max(GRACE_FRAMES,DEAD_HOLD)).
// TESTING
//  1. rst=1 two clk, release -> gameState=00, hit=0, restart=0.
//     jump pulse -> gameState=01 exactly 4 clk after jump rises.
//  2. PLAY past grace (9 frame ticks); 4 overlap clk in one frame, then tick -> gameState=10, hit=1.
//     3 overlap clk instead -> stays 01.
//  3. Overlap of 100 clk in frames 1..8 after start -> stays 01; same overlap in frame 9 -> 10.
//  4. DEAD: jump at frame 10 -> ignored. Jump after 30 ticks -> gameState=00, one-clk restart=1, hit=0.
//  5. jump held high through DEAD_HOLD expiry -> no restart until released and re-pressed.
//  6. rst asserted in PLAY with overlap pending -> 00 next clk, restart=0.
//     jump and frame_clk edges coincident in INIT -> 01, counter=0.

Source files
------------

// File: rtl/trex_defs.sv
// Shared game definitions: state encoding seen by every game delegate, plus
// the default tuning constants of the master game controller.
package trex_defs;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } game_state_e;

    localparam int unsigned HIT_THRESH_DEF   = 4;
    localparam int unsigned GRACE_FRAMES_DEF = 8;
    localparam int unsigned DEAD_HOLD_DEF    = 30;
    localparam int unsigned CNT_W_DEF        = 12;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector; pulse_o is high for one clk, 3 clk after the input rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Master game FSM (INIT/PLAY/DEAD) with per-frame dino/obstacle overlap
// counting, start-of-play grace period and post-death restart hold-off.
module game_state_ctrl
    import trex_defs::*;
#(
    parameter int unsigned HIT_THRESH   = HIT_THRESH_DEF,
    parameter int unsigned GRACE_FRAMES = GRACE_FRAMES_DEF,
    parameter int unsigned DEAD_HOLD    = DEAD_HOLD_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_clk,
    input  logic       jump,
    input  logic       dino_px,
    input  logic       obs_px,
    output logic [1:0] gameState,
    output logic       restart,
    output logic       hit
);

    localparam int unsigned TMR_MAX = (GRACE_FRAMES > DEAD_HOLD) ? GRACE_FRAMES : DEAD_HOLD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic frame_tick;
    logic jump_rise;

    game_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             restart_q, restart_d;
    logic             hit_q, hit_d;
    logic             over_thresh;
    logic             tmr_zero;

    edge_sync u_frame_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (frame_clk),
        .pulse_o (frame_tick)
    );

    edge_sync u_jump_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (jump),
        .pulse_o (jump_rise)
    );

    // Overlap counter: evaluated and cleared on the frame tick, saturating otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (frame_tick) begin
            cnt_d = '0;
        end else if (dino_px && obs_px && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign over_thresh = (cnt_q >= CNT_W'(HIT_THRESH));
    assign tmr_zero    = (tmr_q == '0);

    // Next state; tmr_q counts grace frames in PLAY and hold frames in DEAD
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        restart_d = 1'b0;
        hit_d     = hit_q;
        unique case (state_q)
            ST_INIT: begin
                if (jump_rise) begin
                    state_d = ST_PLAY;
                    tmr_d   = TMR_W'(GRACE_FRAMES);
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (tmr_zero && over_thresh) begin
                        state_d = ST_DEAD;
                        hit_d   = 1'b1;
                        tmr_d   = TMR_W'(DEAD_HOLD);
                    end else if (!tmr_zero) begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            ST_DEAD: begin
                if (jump_rise && tmr_zero) begin
                    state_d   = ST_INIT;
                    restart_d = 1'b1;
                    hit_d     = 1'b0;
                end else if (frame_tick && !tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                hit_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            tmr_q     <= '0;
            restart_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            restart_q <= restart_d;
            hit_q     <= hit_d;
        end
    end

    assign gameState = state_q;
    assign restart   = restart_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: start latency, grace, hit threshold,
// dead hold-off, edge-only restart, reset priority and coincident edges.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_clk = 1'b0;
    logic       jump = 1'b0;
    logic       dino_px = 1'b0;
    logic       obs_px = 1'b0;
    logic [1:0] gameState;
    logic       restart;
    logic       hit;

    int checks = 0;
    int failures = 0;
    int restart_cnt = 0;

    game_state_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame_clk (frame_clk),
        .jump      (jump),
        .dino_px   (dino_px),
        .obs_px    (obs_px),
        .gameState (gameState),
        .restart   (restart),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (restart === 1'b1) restart_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (5) @(negedge clk);
            frame_clk = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic overlap(input int n);
        dino_px = 1'b1;
        obs_px  = 1'b1;
        repeat (n) @(negedge clk);
        dino_px = 1'b0;
        obs_px  = 1'b0;
    endtask

    task automatic press();
        jump = 1'b1;
        repeat (5) @(negedge clk);
        jump = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and start latency
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", 32'(gameState), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_restart", 32'(restart), 32'd0);
        jump = 1'b1;
        repeat (3) @(negedge clk);
        check("start_lat3", 32'(gameState), 32'd0);
        @(negedge clk);
        check("start_lat4", 32'(gameState), 32'd1);
        jump = 1'b0;
        repeat (3) @(negedge clk);

        // Threshold and per-frame clearing once grace has expired
        tick(9);
        check("grace_over", 32'(gameState), 32'd1);
        overlap(3);
        tick(1);
        check("ovl3_alive", 32'(gameState), 32'd1);
        overlap(2);
        tick(1);
        overlap(2);
        tick(1);
        check("ovl_cleared", 32'(gameState), 32'd1);
        overlap(4);
        tick(1);
        check("ovl4_dead", 32'(gameState), 32'd2);
        check("ovl4_hit", 32'(hit), 32'd1);

        // Dead hold-off: jumps ignored until 30 ticks have elapsed
        tick(10);
        press();
        check("hold20_jump", 32'(gameState), 32'd2);
        tick(19);
        press();
        check("hold1_jump", 32'(gameState), 32'd2);
        check("hold_no_restart", 32'(restart_cnt), 32'd0);
        tick(1);
        jump = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_early", 32'(restart), 32'd0);
        @(negedge clk);
        check("restart_state", 32'(gameState), 32'd0);
        check("restart_pulse", 32'(restart), 32'd1);
        check("restart_hit_clr", 32'(hit), 32'd0);
        @(negedge clk);
        check("restart_1clk", 32'(restart), 32'd0);
        jump = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_count1", 32'(restart_cnt), 32'd1);

        // Heavy overlap through the grace frames, then a fatal 9th frame
        press();
        check("play2", 32'(gameState), 32'd1);
        for (int f = 0; f < 8; f++) begin
            overlap(100);
            tick(1);
        end
        check("grace_100", 32'(gameState), 32'd1);
        overlap(100);
        tick(1);
        check("frame9_dead", 32'(gameState), 32'd2);
        check("frame9_hit", 32'(hit), 32'd1);

        // Jump held across hold expiry must not restart
        jump = 1'b1;
        tick(30);
        repeat (5) @(negedge clk);
        check("held_jump", 32'(gameState), 32'd2);
        jump = 1'b0;
        repeat (3) @(negedge clk);
        press();
        check("repress_init", 32'(gameState), 32'd0);
        check("restart_count2", 32'(restart_cnt), 32'd2);

        // Reset in PLAY with overlap pending
        press();
        check("play3", 32'(gameState), 32'd1);
        dino_px = 1'b1;
        obs_px  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(gameState), 32'd0);
        check("midrst_restart", 32'(restart), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        rst = 1'b0;
        dino_px = 1'b0;
        obs_px  = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_count", 32'(restart_cnt), 32'd2);

        // Coincident jump and frame edges in INIT: full grace, cleared counter
        overlap(10);
        jump      = 1'b1;
        frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("coinc_lat3", 32'(gameState), 32'd0);
        @(negedge clk);
        check("coinc_play", 32'(gameState), 32'd1);
        repeat (2) @(negedge clk);
        jump      = 1'b0;
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        tick(7);
        overlap(4);
        tick(1);
        check("coinc_grace8", 32'(gameState), 32'd1);
        overlap(4);
        tick(1);
        check("coinc_hit", 32'(gameState), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
